// File: rtl/exec_cond_stage.sv
// ============================================================================
// Module      : exec_cond_stage
// Description : Execute-stage control register, NZCV flags and condition gating
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_cond_stage #(
    parameter logic [3:0] FLAG_RST     = 4'b0000,
    parameter bit         COND_NV_EXEC = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       MemtoRegD,
    input  logic       ALUSrcD,
    input  logic       BranchD,
    input  logic       NoWriteD,
    input  logic [2:0] ALUControlD,
    input  logic [1:0] FlagWD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlags,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       BranchTakenE,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       CondExE,
    output logic [3:0] Flags
);

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       nowrite;
        logic [2:0] alu;
        logic [1:0] flagw;
        logic [3:0] cond;
    } ectl_t;

    localparam logic [3:0] c_COND_AL = 4'b1110;
    // A bubble carries no side effects but still reads as condition-passing.
    localparam ectl_t      c_BUBBLE  = ectl_t'({12'b0, c_COND_AL});

    ectl_t      ectl_q, ectl_d;
    logic [3:0] flags_q, flags_d;
    logic       w_cond_ex;
    logic [1:0] w_flag_wr;
    logic       w_n, w_z, w_c, w_v;

    always_comb begin
        ectl_d = ectl_q;
        if (FlushE) begin
            ectl_d = c_BUBBLE;
        end else if (!StallE) begin
            ectl_d = '{pcs: PCSD, regw: RegWD, memw: MemWD, memtoreg: MemtoRegD,
                       alusrc: ALUSrcD, branch: BranchD, nowrite: NoWriteD,
                       alu: ALUControlD, flagw: FlagWD, cond: CondD};
        end
    end

    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        w_cond_ex = 1'b0;
        case (ectl_q.cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = COND_NV_EXEC;
        endcase
    end

    assign w_flag_wr = ectl_q.flagw & {2{w_cond_ex}};

    // Flags commit only on non-stalled edges; a flush of the E register does not block them.
    always_comb begin
        flags_d = flags_q;
        if (!StallE) begin
            if (w_flag_wr[1]) flags_d[3:2] = ALUFlags[3:2];
            if (w_flag_wr[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ectl_q  <= c_BUBBLE;
            flags_q <= FLAG_RST;
        end else begin
            ectl_q  <= ectl_d;
            flags_q <= flags_d;
        end
    end

    assign PCSrcE       = ectl_q.pcs & w_cond_ex;
    assign RegWriteE    = ectl_q.regw & w_cond_ex & ~ectl_q.nowrite;
    assign MemWriteE    = ectl_q.memw & w_cond_ex;
    assign BranchTakenE = ectl_q.branch & w_cond_ex;
    assign MemtoRegE    = ectl_q.memtoreg;
    assign ALUSrcE      = ectl_q.alusrc;
    assign ALUControlE  = ectl_q.alu;
    assign CondExE      = w_cond_ex;
    assign Flags        = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_cond_stage.sv
// ============================================================================
// Module      : tb_exec_cond_stage
// Description : Self-checking bench for exec_cond_stage against a reference model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_cond_stage;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       nowrite;
        logic [2:0] alu;
        logic [1:0] fw;
        logic [3:0] cond;
    } d_t;

    localparam logic [3:0] c_AL = 4'b1110;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, flush;
    d_t         cur_d;
    logic [3:0] aluf;

    logic       PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE, CondExE;
    logic [2:0] ALUControlE;
    logic [3:0] Flags;

    int checks   = 0;
    int failures = 0;

    // Reference model: instruction occupying E and architectural flags
    d_t         m_e;
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    exec_cond_stage #(.FLAG_RST(4'b0000), .COND_NV_EXEC(1'b0)) dut (
        .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush),
        .PCSD(cur_d.pcs), .RegWD(cur_d.regw), .MemWD(cur_d.memw),
        .MemtoRegD(cur_d.memtoreg), .ALUSrcD(cur_d.alusrc), .BranchD(cur_d.branch),
        .NoWriteD(cur_d.nowrite), .ALUControlD(cur_d.alu), .FlagWD(cur_d.fw),
        .CondD(cur_d.cond), .ALUFlags(aluf),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .CondExE(CondExE), .Flags(Flags)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic d_t mk(input logic pcs, input logic regw, input logic memw,
                              input logic branch, input logic nowrite,
                              input logic [1:0] fw, input logic [3:0] cond);
        d_t d;
        d = '0;
        d.pcs = pcs; d.regw = regw; d.memw = memw; d.branch = branch;
        d.nowrite = nowrite; d.fw = fw; d.cond = cond;
        d.alu = 3'($urandom);
        d.memtoreg = 1'($urandom);
        d.alusrc = 1'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_e = '0;
        m_e.cond = c_AL;
        m_flags = 4'b0000;
    endtask

    task automatic model_update();
        logic ok;
        if (reset) begin
            model_reset();
        end else begin
            ok = cond_pass(m_e.cond, m_flags);
            if (!stall && ok) begin
                if (m_e.fw[1]) m_flags[3:2] = aluf[3:2];
                if (m_e.fw[0]) m_flags[1:0] = aluf[1:0];
            end
            if (flush) begin
                m_e = '0;
                m_e.cond = c_AL;
            end else if (!stall) begin
                m_e = cur_d;
            end
        end
    endtask

    task automatic compare_model();
        logic       ok;
        logic [9:0] exp_o;
        ok = cond_pass(m_e.cond, m_flags);
        exp_o = {m_e.pcs & ok, m_e.regw & ok & ~m_e.nowrite, m_e.memw & ok,
                 m_e.branch & ok, m_e.memtoreg, m_e.alusrc, m_e.alu, ok};
        check_val("outs", {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE,
                           ALUSrcE, ALUControlE, CondExE}, exp_o);
        check_val("flags", Flags, m_flags);
    endtask

    // One clock: model consumes the edge, then new D inputs and ALUFlags for the
    // instruction currently in E are driven and outputs are compared mid-cycle.
    task automatic load(input d_t d, input logic [3:0] af, input logic st, input logic fl);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cur_d = d; aluf = af; stall = st; flush = fl;
        #1;
        compare_model();
    endtask

    d_t         nop, rnd;
    logic [3:0] snap;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; cur_d = '0; aluf = 4'b0000;
        model_reset();
        nop = mk(0, 0, 0, 0, 0, 2'b00, c_AL);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_flags", Flags, 4'b0000);
        check_val("rst_condex", CondExE, 1'b1);
        check_val("rst_outs", {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE,
                               ALUSrcE, ALUControlE}, 9'd0);
        reset = 1'b0;

        // Asynchronous reset from a live state with all flags set
        load(mk(0, 0, 0, 0, 0, 2'b11, c_AL), 4'($urandom), 0, 0);
        load(mk(1, 1, 1, 1, 0, 2'b00, c_AL), 4'b1111, 0, 0);
        load(nop, 4'($urandom), 0, 0);
        check_val("t1_pre_flags", Flags, 4'b1111);
        check_val("t1_pre_regw", RegWriteE, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_val("t1_flags", Flags, 4'b0000);
        check_val("t1_wr", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE}, 4'b0000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ADDS then BEQ
        load(mk(0, 1, 0, 0, 0, 2'b11, c_AL), 4'($urandom), 0, 0);
        load(mk(1, 0, 0, 1, 0, 2'b00, 4'b0000), 4'b0100, 0, 0);
        load(nop, 4'($urandom), 0, 0);
        check_val("t2_flags", Flags, 4'b0100);
        check_val("t2_branch", {BranchTakenE, PCSrcE}, 2'b11);

        // SUBNE fails with Z set
        load(mk(0, 1, 0, 0, 0, 2'b11, 4'b0001), 4'($urandom), 0, 0);
        load(nop, 4'b1000, 0, 0);
        check_val("t3_condex", CondExE, 1'b0);
        check_val("t3_regw", RegWriteE, 1'b0);
        load(nop, 4'($urandom), 0, 0);
        check_val("t3_flags", Flags, 4'b0100);

        // CMP then GE
        load(mk(0, 1, 0, 0, 1, 2'b11, c_AL), 4'($urandom), 0, 0);
        load(mk(0, 1, 0, 0, 0, 2'b00, 4'b1010), 4'b0010, 0, 0);
        check_val("t4_regw", RegWriteE, 1'b0);
        load(nop, 4'($urandom), 0, 0);
        check_val("t4_flags", Flags, 4'b0010);
        check_val("t4_ge", CondExE, 1'b1);

        // STR held in E for three stalled cycles while ALUFlags toggle
        load(mk(0, 0, 1, 0, 0, 2'b11, c_AL), 4'($urandom), 0, 0);
        snap = m_flags;
        for (int i = 0; i < 3; i++) begin
            rnd = d_t'(16'($urandom));
            load(rnd, (i % 2 == 0) ? 4'b1010 : 4'b0101, 1, 0);
            check_val("t5_memw", MemWriteE, 1'b1);
            check_val("t5_flags", Flags, snap);
        end
        load(mk(0, 1, 0, 0, 0, 2'b00, c_AL), 4'b1001, 0, 0);
        check_val("t5_rel_memw", MemWriteE, 1'b1);
        load(nop, 4'($urandom), 0, 0);
        check_val("t5_next", {RegWriteE, MemWriteE, Flags}, {2'b10, 4'b1001});

        // Stall+flush bubble across every condition and flag value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                load(mk(0, 0, 0, 0, 0, 2'b11, c_AL), 4'($urandom), 0, 0);
                load(mk(1, 1, 1, 1, 0, 2'($urandom), 4'(c)), 4'(f), 0, 0);
                load(nop, 4'($urandom), 1, 1);
                check_val("t6_cond", CondExE, cond_pass(4'(c), 4'(f)));
                load(nop, 4'($urandom), 0, 0);
                check_val("t6_bubble", {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE},
                          5'b00001);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = d_t'(16'($urandom));
            load(rnd, 4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
